banked_regfile: RTL and testbench
=================================

# banked_regfile

Parametrised ARM7TDMI general-purpose register file with per-mode banking. Holds 31 physical registers and 5 SPSRs, maps 4-bit architectural register numbers to physical storage from the current processor mode, and performs atomic exception entry by writing banked LR and SPSR together. Sits between the decode/operand-fetch stage and the ALU/writeback path, and replaces the flat 16-entry file.

## Interface
Parameters:
- DATA_W, 32, width of every register and SPSR
- BYPASS, 1, 1 = a read of the register being written this cycle returns write_data; 0 = returns stored value
- RESET_VALUE, 0, value loaded into every register and SPSR on reset

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock with reset high initialises all state
- mode  in  5  current CPSR[4:0] mode field
- user_bank  in  1  forces read and write mapping to the USR bank (LDM/STM with ^)
- read_reg_num1, read_reg_num2  in  4  architectural read addresses
- read_data1, read_data2  out  DATA_W  combinational read data
- write_reg  in  4  architectural write address
- write_data  in  DATA_W  write data
- regwrite  in  1  write enable
- spsr_rdata  out  DATA_W  SPSR of current mode
- spsr_wdata  in  DATA_W  SPSR write data
- spsr_write  in  1  SPSR write enable
- exc_entry  in  1  exception entry strobe
- exc_mode  in  5  target mode of exception
- exc_lr  in  DATA_W  return address for banked r14
- exc_cpsr  in  DATA_W  pre-exception CPSR, saved into target SPSR

## Operation
- Mode codes: USR 10000, FIQ 10001, IRQ 10010, SVC 10011, ABT 10111, UND 11011, SYS 11111. Any other code maps as USR.
- Banking: r0-r7 and r15 shared by all modes. FIQ banks r8-r14. IRQ/SVC/ABT/UND each bank r13-r14. USR and SYS share the user bank. Physical count: 16 + 7 + 4x2 = 31.
- user_bank=1 overrides mode for register reads/writes (not SPSR, not exc_entry).
- SPSR: one per FIQ/IRQ/SVC/ABT/UND. In USR/SYS/invalid mode spsr_rdata = 0 and spsr_write is ignored.
- regwrite: write_data stored into the physical register mapped from write_reg under the effective mode.
- exc_entry: r14 of exc_mode's bank <= exc_lr and SPSR of exc_mode <= exc_cpsr, same edge. exc_mode of USR/SYS/invalid: entry ignored entirely.
- Bypass (BYPASS=1): if regwrite and read address maps to the same physical register as write_reg, read_data = write_data. If exc_entry targets a physical register being read, read_data = exc_lr. spsr_rdata bypasses spsr_wdata / exc_cpsr likewise when mapping matches. BYPASS=0: all reads show stored state only.
- Priority per physical register: reset > exc_entry > regwrite/spsr_write. Non-conflicting regwrite and exc_entry both complete in the same cycle.
- r15 is plain storage; PC increment lives outside this block.

## Timing
- Reads: zero latency, combinational from address, mode, user_bank and stored state (plus bypass).
- Writes: visible in stored state one cycle after the enabling edge.
- Mode change: new mapping takes effect in the same cycle mode changes; no internal mode register.
- Reset: all 31 registers and 5 SPSRs = RESET_VALUE after the reset edge; writes and exc_entry in a reset cycle are dropped. read_data1/2 and spsr_rdata are then RESET_VALUE (SPSR 0 in USR). Reset asserted mid-stream discards that cycle's write.
- No handshake; every enable is single-cycle and acted on at the edge it is high.

## Test plan
- Reset, mode=USR, write r3=0xDEADBEEF; next cycle read r3 -> 0xDEADBEEF; read r13 -> 0x0.
- mode=USR write r13=0x1000; mode=SVC write r13=0x2000; mode=FIQ write r8=0x8; read back in USR: r13=0x1000, r8=0x0; in SVC r13=0x2000; in SYS r13=0x1000.
- mode=USR, exc_entry exc_mode=IRQ exc_lr=0x104 exc_cpsr=0x10 -> next cycle mode=IRQ: r14=0x104, spsr_rdata=0x10; USR r14 unchanged.
- Same cycle regwrite r14 (mode=IRQ) 0x55 and exc_entry IRQ exc_lr=0x200 -> IRQ r14=0x200; regwrite r2=0x7 alongside -> r2=0x7.
- BYPASS=1: regwrite r5=0xA5 with read_reg_num1=5 -> read_data1=0xA5 same cycle; BYPASS=0 -> old value.
- mode=SVC, user_bank=1, write r13=0x3000 -> USR r13=0x3000, SVC r13 unchanged; spsr_write in USR ignored, spsr_rdata=0.

Source files
------------

// File: rtl/banked_regfile.sv
// ARM7TDMI general-purpose register file: 31 physical registers and 5 SPSRs,
// banked by processor mode, with atomic exception entry (banked LR + SPSR).
module banked_regfile #(
   parameter int unsigned            DATA_W      = 32,
   parameter bit                     BYPASS      = 1'b1,
   parameter logic [DATA_W-1:0]      RESET_VALUE = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [4:0]        mode,
   input  logic              user_bank,
   input  logic [3:0]        read_reg_num1,
   input  logic [3:0]        read_reg_num2,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   input  logic [3:0]        write_reg,
   input  logic [DATA_W-1:0] write_data,
   input  logic              regwrite,
   output logic [DATA_W-1:0] spsr_rdata,
   input  logic [DATA_W-1:0] spsr_wdata,
   input  logic              spsr_write,
   input  logic              exc_entry,
   input  logic [4:0]        exc_mode,
   input  logic [DATA_W-1:0] exc_lr,
   input  logic [DATA_W-1:0] exc_cpsr
);

   typedef enum logic [2:0] {
      BANK_USR = 3'd0,
      BANK_FIQ = 3'd1,
      BANK_IRQ = 3'd2,
      BANK_SVC = 3'd3,
      BANK_ABT = 3'd4,
      BANK_UND = 3'd5
   } bank_e;

   logic [DATA_W-1:0] regs [31];
   logic [DATA_W-1:0] spsr [5];

   function automatic bank_e bank_of(input logic [4:0] m);
      case (m)
         5'b10001: return BANK_FIQ;
         5'b10010: return BANK_IRQ;
         5'b10011: return BANK_SVC;
         5'b10111: return BANK_ABT;
         5'b11011: return BANK_UND;
         default:  return BANK_USR;   // USR, SYS and undefined codes
      endcase
   endfunction

   // Layout: 0-15 user bank, 16-22 FIQ r8-r14, then r13/r14 pairs for IRQ, SVC, ABT, UND.
   function automatic logic [4:0] phys_of(input bank_e b, input logic [3:0] r);
      logic [4:0] idx;
      logic [4:0] base;
      idx  = {1'b0, r};
      base = 5'd0;
      case (b)
         BANK_IRQ: base = 5'd23;
         BANK_SVC: base = 5'd25;
         BANK_ABT: base = 5'd27;
         BANK_UND: base = 5'd29;
         default:  base = 5'd0;
      endcase
      if (b == BANK_FIQ && r >= 4'd8 && r <= 4'd14)
         idx = {1'b0, r} + 5'd8;
      else if (base != 5'd0 && (r == 4'd13 || r == 4'd14))
         idx = base + {4'b0, ~r[0]};
      return idx;
   endfunction

   function automatic logic [2:0] spsr_of(input bank_e b);
      return (b == BANK_USR) ? 3'd0 : (3'(b) - 3'd1);
   endfunction

   bank_e      cur_bank;
   bank_e      reg_bank;
   bank_e      exc_bank;
   logic       exc_ok;
   logic       spsr_ok;
   logic       byp_ok;
   logic [4:0] wr_phys;
   logic [4:0] rd1_phys;
   logic [4:0] rd2_phys;
   logic [4:0] exc_phys;
   logic [2:0] cur_spsr;
   logic [2:0] exc_spsr;

   always_comb begin
      cur_bank = bank_of(mode);
      reg_bank = user_bank ? BANK_USR : cur_bank;
      exc_bank = bank_of(exc_mode);
      exc_ok   = exc_entry && (exc_bank != BANK_USR);
      spsr_ok  = spsr_write && (cur_bank != BANK_USR);
      byp_ok   = BYPASS && !reset;
      wr_phys  = phys_of(reg_bank, write_reg);
      rd1_phys = phys_of(reg_bank, read_reg_num1);
      rd2_phys = phys_of(reg_bank, read_reg_num2);
      exc_phys = phys_of(exc_bank, 4'd14);
      cur_spsr = spsr_of(cur_bank);
      exc_spsr = spsr_of(exc_bank);
   end

   // Exception entry is assigned last so it overrides a colliding regwrite/spsr_write.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < 31; i++) regs[i] <= RESET_VALUE;
         for (int unsigned i = 0; i < 5; i++)  spsr[i] <= RESET_VALUE;
      end else begin
         if (regwrite) regs[wr_phys]  <= write_data;
         if (spsr_ok)  spsr[cur_spsr] <= spsr_wdata;
         if (exc_ok) begin
            regs[exc_phys] <= exc_lr;
            spsr[exc_spsr] <= exc_cpsr;
         end
      end
   end

   always_comb begin
      read_data1 = regs[rd1_phys];
      if (byp_ok && regwrite && rd1_phys == wr_phys) read_data1 = write_data;
      if (byp_ok && exc_ok && rd1_phys == exc_phys)  read_data1 = exc_lr;
   end

   always_comb begin
      read_data2 = regs[rd2_phys];
      if (byp_ok && regwrite && rd2_phys == wr_phys) read_data2 = write_data;
      if (byp_ok && exc_ok && rd2_phys == exc_phys)  read_data2 = exc_lr;
   end

   always_comb begin
      spsr_rdata = '0;
      if (cur_bank != BANK_USR) begin
         spsr_rdata = spsr[cur_spsr];
         if (byp_ok && spsr_ok) spsr_rdata = spsr_wdata;
         if (byp_ok && exc_ok && exc_bank == cur_bank) spsr_rdata = exc_cpsr;
      end
   end

endmodule

// File: tb/tb_banked_regfile.sv
// Self-checking bench for banked_regfile: directed scenarios plus randomized traffic
// checked against a per-bank array model, with BYPASS=1 and BYPASS=0 instances.
module tb_banked_regfile;

   localparam logic [4:0] USR = 5'b10000, FIQ = 5'b10001, IRQ = 5'b10010, SVC = 5'b10011;
   localparam logic [4:0] ABT = 5'b10111, UND = 5'b11011, SYS = 5'b11111;

   logic        clock = 1'b0;
   logic        reset, user_bank, regwrite, spsr_write, exc_entry;
   logic [4:0]  mode, exc_mode;
   logic [3:0]  read_reg_num1, read_reg_num2, write_reg;
   logic [31:0] write_data, spsr_wdata, exc_lr, exc_cpsr;
   logic [31:0] rd1_b, rd2_b, sp_b, rd1_n, rd2_n, sp_n;

   int total = 0;
   int bad = 0;

   // Model: one 16-entry view per bank (0 USR, 1 FIQ, 2 IRQ, 3 SVC, 4 ABT, 5 UND).
   logic [31:0] m_reg  [6][16];
   logic [31:0] m_spsr [6];

   always #5 clock = ~clock;

   banked_regfile #(.DATA_W(32), .BYPASS(1'b1), .RESET_VALUE(32'h0)) dut_b (
      .clock(clock), .reset(reset), .mode(mode), .user_bank(user_bank),
      .read_reg_num1(read_reg_num1), .read_reg_num2(read_reg_num2),
      .read_data1(rd1_b), .read_data2(rd2_b),
      .write_reg(write_reg), .write_data(write_data), .regwrite(regwrite),
      .spsr_rdata(sp_b), .spsr_wdata(spsr_wdata), .spsr_write(spsr_write),
      .exc_entry(exc_entry), .exc_mode(exc_mode), .exc_lr(exc_lr), .exc_cpsr(exc_cpsr));

   banked_regfile #(.DATA_W(32), .BYPASS(1'b0), .RESET_VALUE(32'h0)) dut_n (
      .clock(clock), .reset(reset), .mode(mode), .user_bank(user_bank),
      .read_reg_num1(read_reg_num1), .read_reg_num2(read_reg_num2),
      .read_data1(rd1_n), .read_data2(rd2_n),
      .write_reg(write_reg), .write_data(write_data), .regwrite(regwrite),
      .spsr_rdata(sp_n), .spsr_wdata(spsr_wdata), .spsr_write(spsr_write),
      .exc_entry(exc_entry), .exc_mode(exc_mode), .exc_lr(exc_lr), .exc_cpsr(exc_cpsr));

   function automatic int bank_id(input logic [4:0] m);
      case (m)
         FIQ: return 1;
         IRQ: return 2;
         SVC: return 3;
         ABT: return 4;
         UND: return 5;
         default: return 0;
      endcase
   endfunction

   // Which bank's copy of architectural register r is visible from bank b.
   function automatic int owner(input int b, input int r);
      if (r < 8 || r == 15) return 0;
      if (b == 1) return 1;
      if (b >= 2 && r >= 13) return b;
      return 0;
   endfunction

   function automatic logic [31:0] exp_read(input bit byp, input logic [3:0] r);
      int eb, o, xb;
      logic [31:0] v;
      eb = user_bank ? 0 : bank_id(mode);
      o  = owner(eb, int'(r));
      v  = m_reg[o][r];
      xb = bank_id(exc_mode);
      if (byp && !reset) begin
         if (regwrite && write_reg == r) v = write_data;
         if (exc_entry && xb != 0 && r == 4'd14 && owner(xb, 14) == o) v = exc_lr;
      end
      return v;
   endfunction

   function automatic logic [31:0] exp_spsr(input bit byp);
      int b;
      logic [31:0] v;
      b = bank_id(mode);
      if (b == 0) return 32'h0;
      v = m_spsr[b];
      if (byp && !reset) begin
         if (spsr_write) v = spsr_wdata;
         if (exc_entry && bank_id(exc_mode) == b) v = exc_cpsr;
      end
      return v;
   endfunction

   task automatic model_edge();
      int eb, xb;
      if (reset) begin
         for (int b = 0; b < 6; b++) begin
            m_spsr[b] = 32'h0;
            for (int r = 0; r < 16; r++) m_reg[b][r] = 32'h0;
         end
      end else begin
         eb = user_bank ? 0 : bank_id(mode);
         xb = bank_id(exc_mode);
         if (regwrite) m_reg[owner(eb, int'(write_reg))][write_reg] = write_data;
         if (spsr_write && bank_id(mode) != 0) m_spsr[bank_id(mode)] = spsr_wdata;
         if (exc_entry && xb != 0) begin
            m_reg[owner(xb, 14)][14] = exc_lr;
            m_spsr[xb] = exc_cpsr;
         end
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
   endtask

   task automatic idle();
      reset = 1'b0; user_bank = 1'b0; regwrite = 1'b0; spsr_write = 1'b0; exc_entry = 1'b0;
      mode = USR; exc_mode = USR; read_reg_num1 = 4'd0; read_reg_num2 = 4'd0; write_reg = 4'd0;
      write_data = '0; spsr_wdata = '0; exc_lr = '0; exc_cpsr = '0;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1; regwrite = 1'b1; write_reg = 4'd3; write_data = 32'h1234;
      tick(); tick();
      idle();
      read_reg_num1 = 4'd3; #1;
      total++;
      if (rd1_b !== 32'h0) begin bad++; $display("FAIL reset_r3 got=%h exp=%h", rd1_b, 32'h0); end
      mode = SVC; read_reg_num2 = 4'd13; #1;
      total++;
      if (rd2_n !== 32'h0 || sp_b !== 32'h0) begin
         bad++; $display("FAIL reset_svc got=%h/%h exp=0/0", rd2_n, sp_b);
      end
   endtask

   task automatic test_user_write();
      idle();
      regwrite = 1'b1; write_reg = 4'd3; write_data = 32'hDEADBEEF;
      tick();
      idle();
      read_reg_num1 = 4'd3; read_reg_num2 = 4'd13; #1;
      total++;
      if (rd1_n !== 32'hDEADBEEF) begin bad++; $display("FAIL usr_r3 got=%h exp=%h", rd1_n, 32'hDEADBEEF); end
      total++;
      if (rd2_n !== 32'h0) begin bad++; $display("FAIL usr_r13 got=%h exp=%h", rd2_n, 32'h0); end
   endtask

   task automatic test_banking();
      idle();
      regwrite = 1'b1; write_reg = 4'd13; write_data = 32'h1000; tick();
      mode = SVC; write_data = 32'h2000; tick();
      mode = FIQ; write_reg = 4'd8; write_data = 32'h8; tick();
      idle();
      read_reg_num1 = 4'd13; read_reg_num2 = 4'd8; #1;
      total++;
      if (rd1_n !== 32'h1000 || rd2_n !== 32'h0) begin
         bad++; $display("FAIL bank_usr got=%h/%h exp=00001000/00000000", rd1_n, rd2_n);
      end
      mode = SVC; #1;
      total++;
      if (rd1_n !== 32'h2000) begin bad++; $display("FAIL bank_svc got=%h exp=%h", rd1_n, 32'h2000); end
      mode = SYS; #1;
      total++;
      if (rd1_n !== 32'h1000) begin bad++; $display("FAIL bank_sys got=%h exp=%h", rd1_n, 32'h1000); end
      mode = FIQ; #1;
      total++;
      if (rd2_n !== 32'h8) begin bad++; $display("FAIL bank_fiq got=%h exp=%h", rd2_n, 32'h8); end
   endtask

   task automatic test_exc_entry();
      idle();
      exc_entry = 1'b1; exc_mode = IRQ; exc_lr = 32'h104; exc_cpsr = 32'h10;
      tick();
      idle();
      mode = IRQ; read_reg_num1 = 4'd14; #1;
      total++;
      if (rd1_n !== 32'h104 || sp_n !== 32'h10) begin
         bad++; $display("FAIL exc_irq got=%h/%h exp=00000104/00000010", rd1_n, sp_n);
      end
      mode = USR; #1;
      total++;
      if (rd1_n !== 32'h0) begin bad++; $display("FAIL exc_usr_r14 got=%h exp=%h", rd1_n, 32'h0); end
   endtask

   task automatic test_exc_conflict();
      idle();
      mode = IRQ; regwrite = 1'b1; write_reg = 4'd14; write_data = 32'h55;
      exc_entry = 1'b1; exc_mode = IRQ; exc_lr = 32'h200; exc_cpsr = 32'h11;
      tick();
      write_reg = 4'd2; write_data = 32'h7; exc_lr = 32'h300;
      tick();
      idle();
      mode = IRQ; read_reg_num1 = 4'd14; read_reg_num2 = 4'd2; #1;
      total++;
      if (rd1_n !== 32'h300) begin bad++; $display("FAIL conflict_r14 got=%h exp=%h", rd1_n, 32'h300); end
      total++;
      if (rd2_n !== 32'h7) begin bad++; $display("FAIL conflict_r2 got=%h exp=%h", rd2_n, 32'h7); end
   endtask

   task automatic test_bypass();
      idle();
      regwrite = 1'b1; write_reg = 4'd5; write_data = 32'hA5; read_reg_num1 = 4'd5; #1;
      total++;
      if (rd1_b !== 32'hA5 || rd1_n !== 32'h0) begin
         bad++; $display("FAIL bypass_r5 got=%h/%h exp=000000a5/00000000", rd1_b, rd1_n);
      end
      tick();
      idle();
      mode = SVC; read_reg_num2 = 4'd14; exc_entry = 1'b1; exc_mode = SVC;
      exc_lr = 32'h77; exc_cpsr = 32'h13; #1;
      total++;
      if (rd2_b !== 32'h77 || rd2_n !== 32'h0 || sp_b !== 32'h13 || sp_n !== 32'h0) begin
         bad++; $display("FAIL bypass_exc got=%h/%h/%h/%h exp=77/0/13/0", rd2_b, rd2_n, sp_b, sp_n);
      end
      tick();
   endtask

   task automatic test_user_bank();
      idle();
      mode = SVC; user_bank = 1'b1; regwrite = 1'b1; write_reg = 4'd13; write_data = 32'h3000;
      tick();
      idle();
      read_reg_num1 = 4'd13; #1;
      total++;
      if (rd1_n !== 32'h3000) begin bad++; $display("FAIL ubank_usr got=%h exp=%h", rd1_n, 32'h3000); end
      mode = SVC; #1;
      total++;
      if (rd1_n !== 32'h2000) begin bad++; $display("FAIL ubank_svc got=%h exp=%h", rd1_n, 32'h2000); end
      mode = USR; spsr_write = 1'b1; spsr_wdata = 32'hFF; #1;
      total++;
      if (sp_b !== 32'h0) begin bad++; $display("FAIL spsr_usr_byp got=%h exp=%h", sp_b, 32'h0); end
      tick();
      idle();
      #1;
      total++;
      if (sp_n !== 32'h0) begin bad++; $display("FAIL spsr_usr got=%h exp=%h", sp_n, 32'h0); end
   endtask

   task automatic test_random();
      logic [4:0] modes [9];
      modes = '{USR, FIQ, IRQ, SVC, ABT, UND, SYS, 5'b00000, 5'b10100};
      for (int i = 0; i < 500; i++) begin
         reset         = ($urandom_range(63) == 0);
         mode          = modes[$urandom_range(8)];
         user_bank     = ($urandom_range(5) == 0);
         read_reg_num1 = 4'($urandom_range(15));
         read_reg_num2 = ($urandom_range(2) == 0) ? 4'd14 : 4'($urandom_range(15));
         regwrite      = ($urandom_range(1) == 1);
         write_reg     = ($urandom_range(3) == 0) ? read_reg_num1 : 4'($urandom_range(15));
         write_data    = $urandom;
         spsr_write    = ($urandom_range(3) == 0);
         spsr_wdata    = $urandom;
         exc_entry     = ($urandom_range(4) == 0);
         exc_mode      = modes[$urandom_range(8)];
         exc_lr        = $urandom;
         exc_cpsr      = $urandom;
         #1;
         total++;
         if (rd1_b !== exp_read(1'b1, read_reg_num1) || rd2_b !== exp_read(1'b1, read_reg_num2)) begin
            bad++;
            $display("FAIL rand_byp_rd i=%0d got=%h/%h exp=%h/%h", i, rd1_b, rd2_b,
                     exp_read(1'b1, read_reg_num1), exp_read(1'b1, read_reg_num2));
         end
         total++;
         if (rd1_n !== exp_read(1'b0, read_reg_num1) || rd2_n !== exp_read(1'b0, read_reg_num2)) begin
            bad++;
            $display("FAIL rand_nobyp_rd i=%0d got=%h/%h exp=%h/%h", i, rd1_n, rd2_n,
                     exp_read(1'b0, read_reg_num1), exp_read(1'b0, read_reg_num2));
         end
         total++;
         if (sp_b !== exp_spsr(1'b1) || sp_n !== exp_spsr(1'b0)) begin
            bad++;
            $display("FAIL rand_spsr i=%0d got=%h/%h exp=%h/%h", i, sp_b, sp_n,
                     exp_spsr(1'b1), exp_spsr(1'b0));
         end
         tick();
      end
      idle();
   endtask

   initial begin
      idle();
      #1;
      test_reset();
      test_user_write();
      test_banking();
      test_exc_entry();
      test_exc_conflict();
      test_bypass();
      test_user_bank();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
